sw_array_scheduler: RTL

//  Job sequencer in front of the Smith-Waterman systolic scoring array. Accepts one job descriptor
//  (query length, target length), streams that job's target bases into the array on en0 or en1,
//  and waits for the matching valid flag. It then returns the score on a valid/ready result port.
//  One job in flight at a time; jobs alternate between slot 0 and slot 1.

---
 rtl/sw_array_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sw_array_scheduler.sv
// Job sequencer for the Smith-Waterman systolic array: accepts a job,
// streams its target bases into the array on the current slot's enable,
// waits for that slot's valid flag and returns the score on a valid/ready port.
module sw_array_scheduler #(
  parameter int SCORE_WIDTH = 12,
  parameter int LENGTH      = 128,
  parameter int LOG_LENGTH  = 7,
  parameter int TLEN_W      = 10,
  parameter int MIN_LAT     = 130,
  parameter int TIMEOUT     = 4095
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [LOG_LENGTH:0]    job_qlen,
  input  logic [TLEN_W-1:0]      job_tlen,
  input  logic                   base_valid,
  output logic                   base_ready,
  input  logic [1:0]             base_in,
  output logic [1:0]             arr_data,
  output logic                   arr_en0,
  output logic                   arr_en1,
  output logic [LOG_LENGTH-1:0]  arr_output_select,
  input  logic [SCORE_WIDTH-1:0] arr_result,
  input  logic                   arr_vld0,
  input  logic                   arr_vld1,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [SCORE_WIDTH-1:0] res_score,
  output logic                   res_err,
  output logic                   res_slot,
  output logic                   busy
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                slot;
  logic                job_legal;
  logic [TLEN_W-1:0]   tlen;
  logic [TLEN_W-1:0]   cnt;
  logic [WCNT_W-1:0]   wcnt;

  logic job_ok;
  logic accept;
  logic base_hs;
  logic last_base;
  logic slot_vld;
  logic capture;
  logic timeout;
  logic res_hs;

  // Handshake strobes and the next-state decision.
  always_comb begin
    state_next = state;
    job_ok     = (job_qlen != {(LOG_LENGTH+1){1'b0}})
              && (job_qlen <= (LOG_LENGTH+1)'(LENGTH))
              && (job_tlen != {TLEN_W{1'b0}});
    accept     = (state == IDLE) && job_valid;
    base_hs    = (state == FEED) && base_valid;
    last_base  = base_hs && (cnt == (tlen - TLEN_W'(1)));
    // Only the valid flag belonging to this job's slot is ever considered.
    slot_vld   = slot ? arr_vld1 : arr_vld0;
    capture    = (state == WAIT) && (wcnt >= WCNT_W'(MIN_LAT)) && slot_vld;
    timeout    = (state == WAIT) && !capture && (wcnt == WCNT_W'(TIMEOUT));
    res_hs     = (state == RESP) && res_ready;
    case (state)
      IDLE:    state_next = accept ? (job_ok ? FEED : RESP) : IDLE;
      FEED:    state_next = last_base ? WAIT : FEED;
      WAIT:    state_next = (capture || timeout) ? RESP : WAIT;
      RESP:    state_next = res_hs ? IDLE : RESP;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Job descriptor, feed counters, array drive and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot              <= 1'b0;
      job_legal         <= 1'b0;
      tlen              <= {TLEN_W{1'b0}};
      cnt               <= {TLEN_W{1'b0}};
      wcnt              <= {WCNT_W{1'b0}};
      arr_data          <= 2'b00;
      arr_en0           <= 1'b0;
      arr_en1           <= 1'b0;
      arr_output_select <= {LOG_LENGTH{1'b0}};
      res_score         <= {SCORE_WIDTH{1'b0}};
      res_err           <= 1'b0;
      res_slot          <= 1'b0;
    end else begin
      // Enables are single-cycle pulses; any cycle without a handshake is a bubble.
      arr_en0 <= 1'b0;
      arr_en1 <= 1'b0;
      if (accept) begin
        // qlen == LENGTH truncates to 0, which is what the array expects.
        arr_output_select <= job_qlen[LOG_LENGTH-1:0];
        tlen              <= job_tlen;
        cnt               <= {TLEN_W{1'b0}};
        res_slot          <= slot;
        job_legal         <= job_ok;
        if (!job_ok) begin
          res_err   <= 1'b1;
          res_score <= {SCORE_WIDTH{1'b0}};
        end
      end
      if (base_hs) begin
        arr_data <= base_in;
        arr_en0  <= ~slot;
        arr_en1  <= slot;
        cnt      <= cnt + TLEN_W'(1);
        if (last_base) begin
          wcnt <= {WCNT_W{1'b0}};
        end
      end
      if (state == WAIT) begin
        // Saturating wait counter.
        if (wcnt != WCNT_W'(TIMEOUT)) begin
          wcnt <= wcnt + WCNT_W'(1);
        end
        if (capture) begin
          res_score <= arr_result;
          res_err   <= 1'b0;
        end else if (timeout) begin
          res_score <= {SCORE_WIDTH{1'b0}};
          res_err   <= 1'b1;
        end
      end
      // Rejected jobs never touched the array, so they do not consume a slot.
      if (res_hs && job_legal) begin
        slot <= ~slot;
      end
    end
  end

  assign job_ready  = (state == IDLE);
  assign base_ready = (state == FEED);
  assign res_valid  = (state == RESP);
  assign busy       = (state != IDLE);

endmodule
